// File: rtl/mold_feed_arbiter.sv
// A/B redundant MoldUDP64 feed arbiter: grants one feed per packet, buffers the 3 header
// beats, forwards packets that carry new messages and drops duplicates, reporting gaps.
module mold_feed_arbiter #(
    parameter int unsigned AXI_DATA_W  = 64,
    parameter int unsigned AXI_KEEP_W  = 8,
    parameter int unsigned SEQ_NUM_W   = 64,
    parameter int unsigned ML_W        = 16,
    parameter logic [15:0] EOS_MSG_CNT = 16'hffff
) (
    input  logic                  clk,
    input  logic                  nreset,
    input  logic                  udp_a_axis_tvalid,
    input  logic [AXI_KEEP_W-1:0] udp_a_axis_tkeep,
    input  logic [AXI_DATA_W-1:0] udp_a_axis_tdata,
    input  logic                  udp_a_axis_tlast,
    input  logic                  udp_a_axis_tuser,
    output logic                  udp_a_axis_tready,
    input  logic                  udp_b_axis_tvalid,
    input  logic [AXI_KEEP_W-1:0] udp_b_axis_tkeep,
    input  logic [AXI_DATA_W-1:0] udp_b_axis_tdata,
    input  logic                  udp_b_axis_tlast,
    input  logic                  udp_b_axis_tuser,
    output logic                  udp_b_axis_tready,
    output logic                  mold_axis_tvalid,
    output logic [AXI_KEEP_W-1:0] mold_axis_tkeep,
    output logic [AXI_DATA_W-1:0] mold_axis_tdata,
    output logic                  mold_axis_tlast,
    output logic                  mold_axis_tuser,
    input  logic                  mold_axis_tready,
    output logic [SEQ_NUM_W-1:0]  seq_expected_o,
    output logic                  synced_o,
    output logic                  gap_v_o,
    output logic [SEQ_NUM_W-1:0]  gap_seq_o,
    output logic                  drop_v_o
);

    typedef enum logic [3:0] {
        StIdle, StCap0, StCap1, StCap2, StDecide, StRpl0, StRpl1, StRpl2, StFwd, StDrop
    } state_e;

    state_e                state_q;
    logic                  sel_q;   // 0 = feed A, 1 = feed B
    logic                  rr_q;    // feed preferred when both are valid
    logic [SEQ_NUM_W-1:0]  expected_q;
    logic                  synced_q;
    logic [AXI_DATA_W-1:0] hdr_data_q [3];
    logic [AXI_KEEP_W-1:0] hdr_keep_q [3];
    logic                  hdr_last_q [3];
    logic                  hdr_user_q [3];

    logic                  in_valid, in_last, in_user, in_ready, grant_b;
    logic [AXI_DATA_W-1:0] in_data;
    logic [AXI_KEEP_W-1:0] in_keep;
    logic [1:0]            cap_idx, rpl_idx;
    logic [SEQ_NUM_W-1:0]  hdr_seq, seq_end;
    logic [ML_W-1:0]       hdr_cnt, cnt_eff;
    logic                  fwd;

    assign seq_expected_o = expected_q;
    assign synced_o       = synced_q;

    assign hdr_seq = {hdr_data_q[2][15:0], hdr_data_q[1][63:16]};
    assign hdr_cnt = hdr_data_q[2][31:16];
    assign cnt_eff = (hdr_cnt == EOS_MSG_CNT) ? '0 : hdr_cnt;
    assign seq_end = hdr_seq + {{(SEQ_NUM_W - ML_W){1'b0}}, cnt_eff};
    assign fwd     = !synced_q || (seq_end > expected_q);
    assign grant_b = udp_b_axis_tvalid && (!udp_a_axis_tvalid || rr_q);

    always_comb begin
        in_valid = sel_q ? udp_b_axis_tvalid : udp_a_axis_tvalid;
        in_data  = sel_q ? udp_b_axis_tdata  : udp_a_axis_tdata;
        in_keep  = sel_q ? udp_b_axis_tkeep  : udp_a_axis_tkeep;
        in_last  = sel_q ? udp_b_axis_tlast  : udp_a_axis_tlast;
        in_user  = sel_q ? udp_b_axis_tuser  : udp_a_axis_tuser;
        cap_idx  = (state_q == StCap1) ? 2'd1 : (state_q == StCap2) ? 2'd2 : 2'd0;
        rpl_idx  = (state_q == StRpl1) ? 2'd1 : (state_q == StRpl2) ? 2'd2 : 2'd0;
        in_ready         = 1'b0;
        mold_axis_tvalid = 1'b0;
        mold_axis_tdata  = '0;
        mold_axis_tkeep  = '0;
        mold_axis_tlast  = 1'b0;
        mold_axis_tuser  = 1'b0;
        unique case (state_q)
            StCap0, StCap1, StCap2, StDrop: in_ready = 1'b1;
            StRpl0, StRpl1, StRpl2: begin
                mold_axis_tvalid = 1'b1;
                mold_axis_tdata  = hdr_data_q[rpl_idx];
                mold_axis_tkeep  = hdr_keep_q[rpl_idx];
                mold_axis_tlast  = hdr_last_q[rpl_idx];
                mold_axis_tuser  = hdr_user_q[rpl_idx];
            end
            StFwd: begin
                mold_axis_tvalid = in_valid;
                mold_axis_tdata  = in_data;
                mold_axis_tkeep  = in_keep;
                mold_axis_tlast  = in_last;
                mold_axis_tuser  = in_user;
                in_ready         = mold_axis_tready;
            end
            default: ;
        endcase
        udp_a_axis_tready = in_ready && !sel_q;
        udp_b_axis_tready = in_ready && sel_q;
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q    <= StIdle;
            sel_q      <= 1'b0;
            rr_q       <= 1'b0;
            expected_q <= '0;
            synced_q   <= 1'b0;
            gap_v_o    <= 1'b0;
            gap_seq_o  <= '0;
            drop_v_o   <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                hdr_data_q[i] <= '0;
                hdr_keep_q[i] <= '0;
                hdr_last_q[i] <= 1'b0;
                hdr_user_q[i] <= 1'b0;
            end
        end else begin
            gap_v_o  <= 1'b0;
            drop_v_o <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (udp_a_axis_tvalid || udp_b_axis_tvalid) begin
                        sel_q   <= grant_b;
                        rr_q    <= !grant_b;
                        state_q <= StCap0;
                    end
                end
                StCap0, StCap1, StCap2: begin
                    if (in_valid) begin
                        hdr_data_q[cap_idx] <= in_data;
                        hdr_keep_q[cap_idx] <= in_keep;
                        hdr_last_q[cap_idx] <= in_last;
                        hdr_user_q[cap_idx] <= in_user;
                        if (state_q == StCap2) begin
                            state_q <= StDecide;
                        end else if (in_last) begin
                            // Too short to hold a full header
                            drop_v_o <= 1'b1;
                            state_q  <= StIdle;
                        end else begin
                            state_q <= (state_q == StCap0) ? StCap1 : StCap2;
                        end
                    end
                end
                StDecide: begin
                    if (fwd) begin
                        gap_v_o    <= synced_q && (hdr_seq > expected_q);
                        gap_seq_o  <= expected_q;
                        expected_q <= seq_end;
                        synced_q   <= 1'b1;
                        state_q    <= StRpl0;
                    end else begin
                        drop_v_o <= 1'b1;
                        state_q  <= hdr_last_q[2] ? StIdle : StDrop;
                    end
                end
                StRpl0: if (mold_axis_tready) state_q <= StRpl1;
                StRpl1: if (mold_axis_tready) state_q <= StRpl2;
                StRpl2: if (mold_axis_tready) state_q <= hdr_last_q[2] ? StIdle : StFwd;
                StFwd:  if (in_valid && in_last && mold_axis_tready) state_q <= StIdle;
                StDrop: if (in_valid && in_last) state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mold_feed_arbiter.sv
// Bench for mold_feed_arbiter: random A/B packet streams checked against a packet-level
// dedup/gap model, plus directed header cases and an asynchronous reset mid-packet.
module tb_mold_feed_arbiter;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
        logic        user;
    } beat_t;

    typedef struct packed {
        int unsigned start;
        int unsigned len;
        logic [63:0] seq;
        logic [15:0] cnt;
    } pkt_t;

    logic        clk = 1'b0;
    logic        nreset;
    logic        udp_a_axis_tvalid, udp_a_axis_tlast, udp_a_axis_tuser, udp_a_axis_tready;
    logic [7:0]  udp_a_axis_tkeep;
    logic [63:0] udp_a_axis_tdata;
    logic        udp_b_axis_tvalid, udp_b_axis_tlast, udp_b_axis_tuser, udp_b_axis_tready;
    logic [7:0]  udp_b_axis_tkeep;
    logic [63:0] udp_b_axis_tdata;
    logic        mold_axis_tvalid, mold_axis_tlast, mold_axis_tuser, mold_axis_tready;
    logic [7:0]  mold_axis_tkeep;
    logic [63:0] mold_axis_tdata;
    logic [63:0] seq_expected_o, gap_seq_o;
    logic        synced_o, gap_v_o, drop_v_o;

    always #5 clk = ~clk;

    mold_feed_arbiter dut (
        .clk               (clk),
        .nreset            (nreset),
        .udp_a_axis_tvalid (udp_a_axis_tvalid),
        .udp_a_axis_tkeep  (udp_a_axis_tkeep),
        .udp_a_axis_tdata  (udp_a_axis_tdata),
        .udp_a_axis_tlast  (udp_a_axis_tlast),
        .udp_a_axis_tuser  (udp_a_axis_tuser),
        .udp_a_axis_tready (udp_a_axis_tready),
        .udp_b_axis_tvalid (udp_b_axis_tvalid),
        .udp_b_axis_tkeep  (udp_b_axis_tkeep),
        .udp_b_axis_tdata  (udp_b_axis_tdata),
        .udp_b_axis_tlast  (udp_b_axis_tlast),
        .udp_b_axis_tuser  (udp_b_axis_tuser),
        .udp_b_axis_tready (udp_b_axis_tready),
        .mold_axis_tvalid  (mold_axis_tvalid),
        .mold_axis_tkeep   (mold_axis_tkeep),
        .mold_axis_tdata   (mold_axis_tdata),
        .mold_axis_tlast   (mold_axis_tlast),
        .mold_axis_tuser   (mold_axis_tuser),
        .mold_axis_tready  (mold_axis_tready),
        .seq_expected_o    (seq_expected_o),
        .synced_o          (synced_o),
        .gap_v_o           (gap_v_o),
        .gap_seq_o         (gap_seq_o),
        .drop_v_o          (drop_v_o)
    );

    beat_t       beats[$];
    pkt_t        pkts[$];
    int          a_ids[$];
    int          b_ids[$];
    beat_t       exp_out[$];
    logic [63:0] exp_gaps[$];
    int          exp_drops, obs_drops;
    logic [63:0] m_expected;
    logic        m_synced;
    bit          stall_en;
    int          n_cmp = 0;
    int          n_err = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic new_pkt(input logic [63:0] seq, input logic [15:0] cnt, input int len,
                           output int id);
        pkt_t p;
        p.start = beats.size();
        p.len   = len;
        p.seq   = seq;
        p.cnt   = cnt;
        for (int b = 0; b < len; b++) begin
            beat_t bt;
            bt.data = {$urandom, $urandom};
            if (b == 1) bt.data[63:16] = seq[47:0];
            if (b == 2) begin
                bt.data[15:0]  = seq[63:48];
                bt.data[31:16] = cnt;
            end
            bt.last = (b == len - 1);
            bt.keep = bt.last ? 8'($urandom_range(1, 255)) : 8'hff;
            bt.user = 1'($urandom_range(0, 1));
            beats.push_back(bt);
        end
        pkts.push_back(p);
        id = pkts.size() - 1;
    endtask

    // Packet-level reference: forward anything that advances the stream, else drop.
    task automatic model_pkt(input int id);
        pkt_t        p = pkts[id];
        logic [63:0] eff, fin;
        if (p.len < 3) begin
            exp_drops++;
            return;
        end
        eff = (p.cnt == 16'hffff) ? 64'd0 : 64'(p.cnt);
        fin = p.seq + eff;
        if (!m_synced || fin > m_expected) begin
            if (m_synced && p.seq > m_expected) exp_gaps.push_back(m_expected);
            m_expected = fin;
            m_synced   = 1'b1;
            for (int b = 0; b < int'(p.len); b++) exp_out.push_back(beats[p.start + b]);
        end else begin
            exp_drops++;
        end
    endtask

    task automatic set_in(input bit fb, input bit v, input beat_t bt);
        if (fb) begin
            udp_b_axis_tvalid = v;
            udp_b_axis_tdata  = bt.data;
            udp_b_axis_tkeep  = bt.keep;
            udp_b_axis_tlast  = bt.last;
            udp_b_axis_tuser  = bt.user;
        end else begin
            udp_a_axis_tvalid = v;
            udp_a_axis_tdata  = bt.data;
            udp_a_axis_tkeep  = bt.keep;
            udp_a_axis_tlast  = bt.last;
            udp_a_axis_tuser  = bt.user;
        end
    endtask

    // First beat is offered without a bubble so arbitration order stays predictable.
    task automatic drive_feed(input bit fb, input int id, input int limit, input bit gaps);
        pkt_t p = pkts[id];
        bit   acc;
        int   guard;
        for (int b = 0; b < int'(p.len) && b < limit; b++) begin
            if (gaps && b > 0 && $urandom_range(0, 3) == 0) begin
                set_in(fb, 1'b0, beats[p.start + b]);
                repeat ($urandom_range(1, 2)) begin
                    @(posedge clk);
                    #1;
                end
            end
            set_in(fb, 1'b1, beats[p.start + b]);
            guard = 0;
            do begin
                @(negedge clk);
                acc = fb ? (udp_b_axis_tvalid && udp_b_axis_tready)
                         : (udp_a_axis_tvalid && udp_a_axis_tready);
                @(posedge clk);
                #1;
                guard++;
            end while (!acc && guard < 4000);
            if (!acc) begin
                check("hs_timeout", 128'(0), 128'(1));
                return;
            end
        end
    endtask

    task automatic run_round(input string name);
        int c;
        exp_drops = 0;
        obs_drops = 0;
        for (int i = 0; i < a_ids.size(); i++) begin
            model_pkt(a_ids[i]);
            model_pkt(b_ids[i]);
        end
        fork
            begin
                for (int i = 0; i < a_ids.size(); i++) drive_feed(1'b0, a_ids[i], 99, 1'b1);
                set_in(1'b0, 1'b0, '0);
            end
            begin
                for (int j = 0; j < b_ids.size(); j++) drive_feed(1'b1, b_ids[j], 99, 1'b1);
                set_in(1'b1, 1'b0, '0);
            end
        join
        c = 0;
        while (c < 3000 && exp_out.size() != 0) begin
            @(posedge clk);
            c++;
        end
        repeat (10) @(posedge clk);
        #1;
        check({name, "_beats_left"}, 128'(exp_out.size()), 128'(0));
        check({name, "_gaps_left"}, 128'(exp_gaps.size()), 128'(0));
        check({name, "_drops"}, 128'(obs_drops), 128'(exp_drops));
        check({name, "_expected"}, 128'(seq_expected_o), 128'(m_expected));
        check({name, "_synced"}, 128'(synced_o), 128'(m_synced));
        a_ids.delete();
        b_ids.delete();
    endtask

    function automatic logic [15:0] pick_cnt();
        int r = $urandom_range(0, 9);
        if (r == 0) return 16'd0;
        if (r == 1) return 16'hffff;
        return 16'($urandom_range(1, 5));
    endfunction

    function automatic int pick_len();
        if ($urandom_range(0, 7) == 0) return $urandom_range(1, 2);
        return $urandom_range(3, 8);
    endfunction

    task automatic gen_round(input logic [63:0] base, input int npairs);
        logic [63:0] cur = base;
        logic [63:0] sa, sb;
        logic [15:0] ca;
        int          id, r;
        for (int i = 0; i < npairs; i++) begin
            ca = pick_cnt();
            sa = cur + 64'($urandom_range(0, 2));
            new_pkt(sa, ca, pick_len(), id);
            a_ids.push_back(id);
            r = $urandom_range(0, 3);
            if (r < 2)       sb = sa;
            else if (r == 2) sb = sa + 64'(ca) + 64'($urandom_range(0, 3));
            else             sb = cur - 64'd1;
            new_pkt(sb, (r < 2) ? ca : pick_cnt(), pick_len(), id);
            b_ids.push_back(id);
            cur = sa + ((ca == 16'hffff) ? 64'd0 : 64'(ca));
        end
    endtask

    initial begin
        logic [127:0] prev_out;
        bit           prev_stall;
        beat_t        e;
        prev_stall = 1'b0;
        prev_out   = '0;
        forever begin
            @(negedge clk);
            if (nreset) begin
                check("excl_ready", 128'(udp_a_axis_tready && udp_b_axis_tready), 128'(0));
                if (prev_stall) begin
                    check("hold_valid", 128'(mold_axis_tvalid), 128'(1));
                    check("hold_data", 128'({mold_axis_tdata, mold_axis_tkeep, mold_axis_tlast,
                                             mold_axis_tuser}), prev_out);
                end
                prev_stall = mold_axis_tvalid && !mold_axis_tready;
                prev_out = 128'({mold_axis_tdata, mold_axis_tkeep, mold_axis_tlast,
                                 mold_axis_tuser});
                if (mold_axis_tvalid && mold_axis_tready) begin
                    if (exp_out.size() == 0) begin
                        check("extra_beat", 128'(1), 128'(0));
                    end else begin
                        e = exp_out.pop_front();
                        check("out_data", 128'(mold_axis_tdata), 128'(e.data));
                        check("out_keep", 128'(mold_axis_tkeep), 128'(e.keep));
                        check("out_last_user", 128'({mold_axis_tlast, mold_axis_tuser}),
                              128'({e.last, e.user}));
                    end
                end
                if (gap_v_o) begin
                    if (exp_gaps.size() == 0) check("extra_gap", 128'(1), 128'(0));
                    else check("gap_seq", 128'(gap_seq_o), 128'(exp_gaps.pop_front()));
                end
                if (drop_v_o) obs_drops++;
            end else begin
                prev_stall = 1'b0;
            end
        end
    end

    initial begin
        mold_axis_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            mold_axis_tready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int id;
        nreset     = 1'b0;
        stall_en   = 1'b0;
        m_expected = '0;
        m_synced   = 1'b0;
        set_in(1'b0, 1'b0, '0);
        set_in(1'b1, 1'b0, '0);
        #3;
        check("rst_a_ready", 128'(udp_a_axis_tready), 128'(0));
        check("rst_b_ready", 128'(udp_b_axis_tready), 128'(0));
        check("rst_out_valid", 128'(mold_axis_tvalid), 128'(0));
        check("rst_pulses", 128'({gap_v_o, drop_v_o}), 128'(0));
        check("rst_expected", 128'(seq_expected_o), 128'(0));
        check("rst_synced", 128'(synced_o), 128'(0));
        repeat (3) @(posedge clk);
        #1;
        nreset = 1'b1;
        @(posedge clk);
        #1;

        // A(1,3) fwd, B dup drop, A heartbeat at expected drop, B(10,2) fwd with gap at 4
        new_pkt(64'd1, 16'd3, 8, id);
        a_ids.push_back(id);
        new_pkt(64'd1, 16'd3, 8, id);
        b_ids.push_back(id);
        new_pkt(64'd4, 16'd0, 3, id);
        a_ids.push_back(id);
        new_pkt(64'd10, 16'd2, 5, id);
        b_ids.push_back(id);
        run_round("dir");
        check("dir_expected_12", 128'(seq_expected_o), 128'(12));

        stall_en = 1'b1;
        gen_round(64'd1, 12);
        run_round("rnd1");
        gen_round(64'hffff_ffff_ffff_fff8, 12);
        run_round("rnd2");

        // Asynchronous reset while a packet is mid pass-through
        stall_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        new_pkt(m_expected, 16'd2, 8, id);
        for (int b = 0; b < 5; b++) exp_out.push_back(beats[pkts[id].start + b]);
        drive_feed(1'b0, id, 5, 1'b0);
        nreset = 1'b0;
        set_in(1'b0, 1'b0, '0);
        #2;
        check("mid_rst_beats_seen", 128'(exp_out.size()), 128'(0));
        check("mid_rst_out_valid", 128'(mold_axis_tvalid), 128'(0));
        check("mid_rst_readys", 128'({udp_a_axis_tready, udp_b_axis_tready}), 128'(0));
        check("mid_rst_expected", 128'(seq_expected_o), 128'(0));
        check("mid_rst_synced", 128'(synced_o), 128'(0));
        m_expected = '0;
        m_synced   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        nreset = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("post_rst_out_valid", 128'(mold_axis_tvalid), 128'(0));
        check("post_rst_expected", 128'(seq_expected_o), 128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
